// File: rtl/response_serializer.sv
// response_serializer: packs one response message into a 48-bit packet and streams it out as bytes.
// Defining RESPONSE_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte to each frame.
module response_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [4:0]  msg_data_type,
  input  logic [1:0]  msg_packet_number,
  input  logic [3:0]  msg_channel,
  input  logic [31:0] msg_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_last,
  output logic        busy,
  output logic        bad_type
);
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  state_t      state_q, state_d;
  logic [47:0] hold_q, hold_d;
  logic [2:0]  idx_q, idx_d;
  logic        bad_q, bad_d;
  logic [2:0]  sel;
  logic [47:0] shifted;
  logic [7:0]  cur_byte;
  logic        legal;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif
  assign legal    = msg_data_type <= 5'd5;
  assign sel      = MSB_FIRST ? 3'd5 - idx_q : idx_q;
  assign shifted  = hold_q >> {sel, 3'b000};
  assign cur_byte = shifted[7:0];
  assign bad_type = bad_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    bad_d   = 1'b0;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (state_q == IDLE && msg_valid) begin
      state_d = SEND;
      hold_d  = {legal ? msg_data_type : 5'd0, 3'b000, msg_packet_number, msg_channel, 2'b00, msg_data};
      idx_d   = '0;
      bad_d   = !legal;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (state_q == SEND && tx_ready) begin
      idx_d = idx_q + 3'd1;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
      csum_d  = csum_q ^ cur_byte;
      state_d = idx_q == 3'd5 ? CSUM : SEND;
`else
      state_d = idx_q == 3'd5 ? IDLE : SEND;
`endif
    end else if (state_q == CSUM && tx_ready) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    msg_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    tx_valid  = state_q != IDLE;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
    tx_byte   = state_q == SEND ? cur_byte : (state_q == CSUM ? csum_q : 8'h00);
    tx_last   = state_q == CSUM;
`else
    tx_byte   = state_q == SEND ? cur_byte : 8'h00;
    tx_last   = state_q == SEND && idx_q == 3'd5;
`endif
  end
endmodule

// File: tb/tb_response_serializer.sv
// tb_response_serializer: directed checks of framing, backpressure, illegal types, back-to-back and reset.
module tb_response_serializer;
  logic        clk = 1'b0, reset = 1'b1, msg_valid = 1'b0, tx_ready = 1'b0;
  logic [4:0]  msg_data_type = '0;
  logic [1:0]  msg_packet_number = '0;
  logic [3:0]  msg_channel = '0;
  logic [31:0] msg_data = '0;
  logic        msg_ready, tx_valid, tx_last, busy, bad_type;
  logic [7:0]  tx_byte;
  logic        msg_ready_l, tx_valid_l, tx_last_l, busy_l, bad_type_l;
  logic [7:0]  tx_byte_l;
  int n_vec = 0, n_err = 0;
`ifdef RESPONSE_SERIALIZER_CHECKSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif
  logic [7:0] exp_basic [7] = '{8'h18, 8'hA8, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h92};
  logic [7:0] exp_lsb   [7] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hA8, 8'h18, 8'h92};
  logic [7:0] exp_ill   [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
  logic [7:0] exp_b2b   [7] = '{8'h08, 8'h4C, 8'h12, 8'h34, 8'h56, 8'h78, 8'h4C};
  logic [7:0] got [8], got_l [8];
  int ntx, nlast, lastpos, bad_hi, bad_first;

  response_serializer #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data_type(msg_data_type), .msg_packet_number(msg_packet_number),
    .msg_channel(msg_channel), .msg_data(msg_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_last(tx_last), .busy(busy),
    .bad_type(bad_type));

  response_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready_l),
    .msg_data_type(msg_data_type), .msg_packet_number(msg_packet_number),
    .msg_channel(msg_channel), .msg_data(msg_data), .tx_valid(tx_valid_l),
    .tx_ready(tx_ready), .tx_byte(tx_byte_l), .tx_last(tx_last_l), .busy(busy_l),
    .bad_type(bad_type_l));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] t, input logic [1:0] p, input logic [3:0] ch, input logic [31:0] d);
    msg_data_type = t; msg_packet_number = p; msg_channel = ch; msg_data = d; msg_valid = 1'b1;
    check("ready_before_send", msg_ready, 1);
    tick;
    msg_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic collect(input logic [3:0] pat, input int stop);
    bit stall = 1'b0;
    logic [7:0] held = '0;
    ntx = 0; nlast = 0; lastpos = -1; bad_hi = 0; bad_first = int'(bad_type);
    for (int c = 0; c < 80 && ntx < stop; c++) begin
      if (stall) begin
        check("stall_valid", tx_valid, 1);
        check("stall_byte", tx_byte, held);
      end
      tx_ready = pat[c % 4];
      bad_hi += int'(bad_type);
      stall = tx_valid && !tx_ready;
      held = tx_byte;
      if (tx_valid && tx_ready) begin
        got[ntx] = tx_byte;
        got_l[ntx] = tx_byte_l;
        if (tx_last) begin
          nlast++;
          lastpos = ntx;
        end
        ntx++;
      end
      tick;
    end
    tx_ready = 1'b0;
    if (ntx < stop) check("timeout_transfers", ntx, stop);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e [7], input bit chk_l, input int exp_bad);
    for (int i = 0; i < FLEN; i++) begin
      check($sformatf("%s_byte%0d", tag, i), got[i], e[i]);
      if (chk_l) check($sformatf("%s_lsb_byte%0d", tag, i), got_l[i], exp_lsb[i]);
    end
    check({tag, "_last_count"}, nlast, 1);
    check({tag, "_last_pos"}, lastpos, FLEN - 1);
    check({tag, "_bad_first"}, bad_first, exp_bad);
    check({tag, "_bad_count"}, bad_hi, exp_bad);
    check({tag, "_no_extra"}, tx_valid, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_msg_ready"}, msg_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_byte"}, tx_byte, 0);
    check({tag, "_tx_last"}, tx_last, 0);
    check({tag, "_bad_type"}, bad_type, 0);
  endtask

  initial begin
    int last_c, acc_c;
    tick; tick;
    check_reset("rst");
    reset = 1'b0;
    tick;
    send(5'd3, 2'd2, 4'hA, 32'hDEADBEEF);
    collect(4'b1111, FLEN);
    check_frame("basic", exp_basic, 1'b1, 0);
    send(5'd3, 2'd2, 4'hA, 32'hDEADBEEF);
    collect(4'b1001, FLEN);
    check_frame("bp", exp_basic, 1'b1, 0);
    send(5'd7, 2'd0, 4'h0, 32'h1);
    collect(4'b1111, FLEN);
    check_frame("ill", exp_ill, 1'b0, 1);
    msg_data_type = 5'd3; msg_packet_number = 2'd2; msg_channel = 4'hA; msg_data = 32'hDEADBEEF;
    msg_valid = 1'b1; tx_ready = 1'b1;
    check("b2b_ready", msg_ready, 1);
    tick;
    msg_data_type = 5'd1; msg_packet_number = 2'd1; msg_channel = 4'h3; msg_data = 32'h12345678;
    last_c = -1; acc_c = -1;
    for (int c = 0; c < 40 && acc_c < 0; c++) begin
      if (tx_valid && tx_last) last_c = c;
      if (msg_ready) acc_c = c;
      tick;
    end
    msg_valid = 1'b0;
    check("b2b_last_seen", last_c >= 0, 1);
    check("b2b_gap", acc_c, last_c + 1);
    collect(4'b1111, FLEN);
    check_frame("b2b", exp_b2b, 1'b0, 0);
    send(5'd3, 2'd2, 4'hA, 32'hDEADBEEF);
    collect(4'b1111, 3);
    check("midrst_partial_last", nlast, 0);
    reset = 1'b1;
    tick;
    check_reset("midrst");
    reset = 1'b0;
    tick;
    send(5'd3, 2'd2, 4'hA, 32'hDEADBEEF);
    collect(4'b1111, FLEN);
    check_frame("post_rst", exp_basic, 1'b1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/response_serializer.md
# response_serializer

Transmit-side framer for the manager's response path. Accepts one response message (data type, packet number, TDC channel, 32-bit payload) per valid/ready handshake, packs it into the 48-bit response packet layout defined in `MessageWrapper`, and streams it out as bytes over a valid/ready byte interface toward the host link (UART/SPI byte engine). It is the counterpart of the command deframer on the receive path.

## Interface
- `MSB_FIRST`, default 1: 1 sends packet bits [47:40] first; 0 sends bits [7:0] first.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `msg_valid`  in  1  response message present.
- `msg_ready`  out  1  block can accept a message; the message is taken when `msg_valid && msg_ready`.
- `msg_data_type`  in  5  `data_type_t` encoding (nack=0 … ack_reset_events_rate=5).
- `msg_packet_number`  in  2  packet index within a multi-packet response.
- `msg_channel`  in  4  `TDC_CHANNEL`.
- `msg_data`  in  32  payload.
- `tx_valid`  out  1  `tx_byte` valid.
- `tx_ready`  in  1  downstream accepts the byte; a byte transfers when `tx_valid && tx_ready`.
- `tx_byte`  out  8  current byte.
- `tx_last`  out  1  high with the final byte of a frame.
- `busy`  out  1  frame in flight; equals `!msg_ready`.
- `bad_type`  out  1  one-cycle pulse when an accepted message carries an illegal data type.

## Operation
- Packet layout, bit 47 down to 0: data_type[4:0], 3'b000, packet_number[1:0], channel[3:0], 2'b00, data[31:0]. Reserved fields are always driven 0.
- Bytes, with `MSB_FIRST`=1: B0=packet[47:40], B1=[39:32], B2..B5 = data[31:24]..data[7:0]. With `MSB_FIRST`=0, the order is reversed (B5 first).
- Illegal data type (value > 5): the packet is sent with data_type = nack (0). All other fields are sent unchanged. `bad_type` pulses in the cycle after acceptance.
- States:
  - IDLE: `msg_ready`=1. On handshake, latch the packet into a 48-bit holding register, clear the byte index, and go to SEND.
  - SEND: `tx_valid`=1 and `tx_byte` = the byte at the current index. On each transfer the index increments.
    - On the transfer of index 5: go to IDLE, or go to CSUM if the checksum is compiled in.
  - CSUM: `tx_valid`=1, `tx_byte` = checksum, `tx_last`=1. On transfer, go to IDLE.
- Stability: once `tx_valid` rises, `tx_byte` and `tx_last` hold until the transfer. `tx_valid` never drops without a transfer.
- `msg_*` inputs are ignored outside IDLE. The holding register is the only copy of the message.
- Reset values: state=IDLE, `msg_ready`=1, `tx_valid`=0, `tx_byte`=0, `tx_last`=0, `busy`=0, `bad_type`=0, index=0, checksum accumulator=0.
- Reset asserted mid-frame: the frame is abandoned. All outputs take their reset values at the next edge, and no partial `tx_last` is issued.

## Timing
- Handshake at edge N: first `tx_valid` at N+1.
- With `tx_ready` held high: bytes transfer on edges N+1..N+6 (N+7 with checksum). `msg_ready` is high again after the last transfer edge.
- Throughput: one idle cycle between frames. Each frame costs 7 cycles (8 with checksum).
- `tx_ready` low stalls the current byte indefinitely, with no loss or duplication.
- `msg_ready` and `busy` are registered state decodes. There is no combinational path from `tx_ready` to `msg_ready`.

## Configuration
- `RESPONSE_SERIALIZER_CHECKSUM_EN` defined: a 7th byte is appended, equal to the XOR of the six packet bytes as transmitted. `tx_last` is asserted on the checksum byte.
- Not defined: frames are 6 bytes, `tx_last` is asserted on the 6th byte, and no checksum logic is present.

## Test plan
- Basic frame, `MSB_FIRST`=1, `tx_ready`=1. Input: type=send_events(3), pkt=2, ch=0xA, data=0xDEADBEEF.
  - Bytes: 0x18, 0xA8, 0xDE, 0xAD, 0xBE, 0xEF. `tx_last` is on 0xEF.
  - With the checksum: a 7th byte 0x18^0xA8^0xDE^0xAD^0xBE^0xEF, with `tx_last` on it.
- Backpressure: same message, with `tx_ready` toggled in a 1-0-0-1 pattern.
  - Identical byte sequence.
  - `tx_byte` is stable during every stall cycle.
  - Exactly 6 (or 7) transfers.
- Illegal type: type=7, pkt=0, ch=0, data=0x1.
  - First byte is 0x00.
  - `bad_type` is a single-cycle pulse one cycle after acceptance.
  - Remaining bytes: 0x00, 0x00, 0x00, 0x00, 0x01.
- Back-to-back: `msg_valid` held high with two messages.
  - The second message is accepted exactly one cycle after the first frame's last transfer.
  - No input is accepted while `busy`=1.
- `MSB_FIRST`=0, using the basic-frame message. Bytes: 0xEF, 0xBE, 0xAD, 0xDE, 0xA8, 0x18.
- Reset after the 3rd byte: outputs return to reset values at the next edge. The next message produces a full, correct frame starting at B0.
